// File: rtl/rewire_bit_collector_if.sv
// rewire_bit_collector_if: valid/ready word stream from the collector to its consumer
interface rewire_bit_collector_if #(parameter int WORD_W = 8);
  logic [WORD_W-1:0] data;
  logic valid;
  logic ready;
  modport master (output data, output valid, input ready);
  modport slave (input data, input valid, output ready);
endinterface

// File: rtl/rewire_bit_collector.sv
// rewire_bit_collector: packs a 1-bit device stream LSB-first into words and queues them in a FIFO (optional drop counter: REWIRE_BIT_COLLECTOR_DROPCNT_EN)
module rewire_bit_collector #(
  parameter int WORD_W = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic flush,
  rewire_bit_collector_if.master m,
  output logic [$clog2(DEPTH):0] level,
  output logic overflow
`ifdef REWIRE_BIT_COLLECTOR_DROPCNT_EN
  ,
  output logic [7:0] drop_count
`endif
);
  localparam int CW = $clog2(WORD_W);
  localparam int AW = $clog2(DEPTH);
  logic [CW-1:0] cnt;
  logic [WORD_W-1:0] sreg, merged;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic complete, push, pop, full, wr_en, drop;
  // merge a same-cycle bit before deciding on a push; a completing bit and a flush yield one push
  always_comb begin
    merged = sreg | (WORD_W'(bit_valid & bit_in) << cnt);
    complete = bit_valid && cnt == CW'(WORD_W - 1);
    push = complete || (flush && (bit_valid || cnt != '0));
    pop = m.valid && m.ready;
    full = level == (AW + 1)'(DEPTH);
    wr_en = push && (!full || pop);
    drop = push && full && !pop;
  end
  // assembler clears on every push, even when the word is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sreg <= '0;
    end else begin
      cnt <= push ? '0 : bit_valid ? cnt + CW'(1) : cnt;
      sreg <= push ? '0 : merged;
    end
  end
  // circular buffer; when full, a same-cycle pop frees the slot being written
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) mem[wr_ptr] <= merged;
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(pop);
      level <= level + (AW + 1)'(wr_en) - (AW + 1)'(pop);
    end
  end
  assign m.data = mem[rd_ptr];
  assign m.valid = level != '0;
`ifdef REWIRE_BIT_COLLECTOR_DROPCNT_EN
  // saturating count of discarded words; overflow is derived from it
  always_ff @(posedge clk) begin
    if (rst) drop_count <= '0;
    else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end
  assign overflow = drop_count != 8'd0;
`else
  // sticky flag for any discarded word
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_rewire_bit_collector.sv
// tb_rewire_bit_collector: directed self-checking bench for rewire_bit_collector
module tb_rewire_bit_collector;
  logic clk = 0, rst = 1, bit_in = 0, bit_valid = 0, flush = 0;
  logic [2:0] level;
  logic overflow;
  int checks = 0, failures = 0;
  rewire_bit_collector_if #(.WORD_W(8)) m_if ();
`ifdef REWIRE_BIT_COLLECTOR_DROPCNT_EN
  logic [7:0] drop_count;
`endif
  rewire_bit_collector #(.WORD_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .flush(flush),
    .m(m_if), .level(level), .overflow(overflow)
`ifdef REWIRE_BIT_COLLECTOR_DROPCNT_EN
    , .drop_count(drop_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    bit_valid = 1;
    bit_in = b;
    step();
    bit_valid = 0;
    bit_in = 0;
  endtask
  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
  endtask
  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask
  task automatic test_reset();
    m_if.ready = 0;
    do_reset();
    checks++; if (m_if.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", m_if.valid); end
    checks++; if (m_if.data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", m_if.data); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
  endtask
  task automatic test_full_word();
    logic [7:0] w = 8'h8D;
    m_if.ready = 1;
    for (int i = 0; i < 7; i++) send_bit(w[i]);
    checks++; if (m_if.valid !== 1'b0) begin failures++; $display("FAIL word_early_valid got=%b exp=0", m_if.valid); end
    send_bit(w[7]);
    checks++; if (m_if.valid !== 1'b1) begin failures++; $display("FAIL word_valid got=%b exp=1", m_if.valid); end
    checks++; if (m_if.data !== 8'h8D) begin failures++; $display("FAIL word_data got=%h exp=8d", m_if.data); end
    step();
    checks++; if (m_if.valid !== 1'b0) begin failures++; $display("FAIL word_one_cycle got=%b exp=0", m_if.valid); end
    m_if.ready = 0;
  endtask
  task automatic test_flush();
    send_bit(1); send_bit(1); send_bit(1);
    flush = 1; step(); flush = 0;
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL flush_level got=%0d exp=1", level); end
    checks++; if (m_if.data !== 8'h07) begin failures++; $display("FAIL flush_data got=%h exp=07", m_if.data); end
    m_if.ready = 1; step(); m_if.ready = 0;
    flush = 1; step(); flush = 0;
    step();
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL flush_empty_level got=%0d exp=0", level); end
  endtask
  task automatic test_flush_same_cycle();
    send_bit(1); send_bit(0);
    flush = 1; send_bit(1); flush = 0;
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL flushbit_level got=%0d exp=1", level); end
    checks++; if (m_if.data !== 8'h05) begin failures++; $display("FAIL flushbit_data got=%h exp=05", m_if.data); end
    m_if.ready = 1; step(); m_if.ready = 0;
    for (int i = 0; i < 7; i++) send_bit(1);
    flush = 1; send_bit(1); flush = 0;
    step();
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL flushfull_level got=%0d exp=1", level); end
    checks++; if (m_if.data !== 8'hFF) begin failures++; $display("FAIL flushfull_data got=%h exp=ff", m_if.data); end
    m_if.ready = 1; step(); m_if.ready = 0;
    checks++; if (m_if.valid !== 1'b0) begin failures++; $display("FAIL flushfull_drain got=%b exp=0", m_if.valid); end
  endtask
  task automatic test_overflow();
    logic [7:0] exp;
    for (int i = 1; i <= 4; i++) send_word(8'(i));
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL ovf_full_level got=%0d exp=4", level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_pre got=%b exp=0", overflow); end
    send_word(8'h05);
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL ovf_level got=%0d exp=4", level); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
`ifdef REWIRE_BIT_COLLECTOR_DROPCNT_EN
    checks++; if (drop_count !== 8'd1) begin failures++; $display("FAIL ovf_dropcnt got=%0d exp=1", drop_count); end
`endif
    m_if.ready = 1;
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(i);
      checks++; if (m_if.data !== exp) begin failures++; $display("FAIL drain_data got=%h exp=%h", m_if.data, exp); end
      step();
    end
    m_if.ready = 0;
    checks++; if (m_if.valid !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL drain_empty valid=%b level=%0d exp=0/0", m_if.valid, level); end
    send_word(8'h66);
    checks++; if (m_if.data !== 8'h66 || level !== 3'd1) begin failures++; $display("FAIL wrap_data got=%h level=%0d exp=66/1", m_if.data, level); end
    m_if.ready = 1; step(); m_if.ready = 0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask
  task automatic test_pop_while_full();
    logic [7:0] w = 8'h06;
    logic [7:0] exp [4] = '{8'h02, 8'h03, 8'h04, 8'h06};
    do_reset();
    for (int i = 1; i <= 4; i++) send_word(8'(i));
    for (int i = 0; i < 7; i++) send_bit(w[i]);
    m_if.ready = 1; send_bit(w[7]); m_if.ready = 0;
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL popfull_level got=%0d exp=4", level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL popfull_overflow got=%b exp=0", overflow); end
    m_if.ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_if.data !== exp[i]) begin failures++; $display("FAIL popfull_data got=%h exp=%h", m_if.data, exp[i]); end
      step();
    end
    m_if.ready = 0;
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL popfull_empty got=%0d exp=0", level); end
  endtask
  task automatic test_reset_mid();
    send_word(8'h11); send_word(8'h22);
    for (int i = 0; i < 4; i++) send_bit(1);
    do_reset();
    checks++; if (m_if.valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", m_if.valid); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL rstmid_level got=%0d exp=0", level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rstmid_overflow got=%b exp=0", overflow); end
    send_word(8'hA5);
    checks++; if (level !== 3'd1 || m_if.data !== 8'hA5) begin failures++; $display("FAIL rstmid_word got=%h level=%0d exp=a5/1", m_if.data, level); end
  endtask
  initial begin
    m_if.ready = 0;
    test_reset();
    test_full_word();
    test_flush();
    test_flush_same_cycle();
    test_overflow();
    test_pop_while_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
